spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//
// Shares one SPI master between two show-ahead requesters (A and B).
// Words are forwarded from the granted requester toward the master. The owner
// of every forwarded word is recorded in a small tag FIFO, so each byte the
// master returns is steered back to the requester that sent the matching word.
//
// Ports
//   clock, reset_n          sole clock (rising edge), async active-low reset
//   a_dc/a_data/a_empty     requester A head word and empty flag
//   a_get                   one-cycle consume strobe toward A
//   a_out/a_put/a_full      returned byte, write strobe, back-pressure from A
//   b_*                     same set for requester B
//   m_dc/m_data/m_empty     head word presented to the SPI master
//   m_get                   master consume strobe
//   m_out/m_put/m_full      returned byte from the master, its strobe, and
//                           back-pressure of the requester owning the head tag
//   grant                   current owner: 00 idle, 01 A, 10 B
//   orphan                  sticky: a returned byte arrived with nothing in flight
// -----------------------------------------------------------------------------
module spi_arbiter #(
   parameter int MAX_BURST = 16,
   parameter int TAG_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   // requester A
   input  logic       a_dc,
   input  logic [7:0] a_data,
   input  logic       a_empty,
   output logic       a_get,
   output logic [7:0] a_out,
   output logic       a_put,
   input  logic       a_full,
   // requester B
   input  logic       b_dc,
   input  logic [7:0] b_data,
   input  logic       b_empty,
   output logic       b_get,
   output logic [7:0] b_out,
   output logic       b_put,
   input  logic       b_full,
   // SPI master side
   output logic       m_dc,
   output logic [7:0] m_data,
   output logic       m_empty,
   input  logic       m_get,
   input  logic [7:0] m_out,
   input  logic       m_put,
   output logic       m_full,
   // status
   output logic [1:0] grant,
   output logic       orphan
);

   localparam int PTR_W   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CNT_W   = $clog2(TAG_DEPTH) + 1;
   localparam int BURST_W = $clog2(MAX_BURST + 1);

   // Encodings double as the grant output value.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_A = 2'b01,
      GNT_B = 2'b10
   } state_t;

   state_t               state_reg, state_next;
   logic                 last_b_reg, last_b_next;     // last-served: 1 = B
   logic [BURST_W-1:0]   burst_reg, burst_next;

   logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]     tag_cnt_reg, tag_cnt_next;
   logic                 orphan_reg, orphan_next;
   logic                 tag_mem [TAG_DEPTH];         // owner id per word: 1 = B

   logic                 owner_empty;
   logic                 tag_full;
   logic                 tag_nonempty;
   logic                 tag_head;
   logic                 fwd_get;
   logic                 tag_pop;
   logic                 rel;
   logic                 prev_b;
   state_t               pick;

   // ------------------------------------------------------------------
   // Forward path: combinational mux from the granted requester
   // ------------------------------------------------------------------
   always_comb begin
      owner_empty = (state_reg == GNT_B) ? b_empty : a_empty;
      tag_full    = (tag_cnt_reg == CNT_W'(TAG_DEPTH));
      m_empty     = (state_reg == IDLE) | owner_empty | tag_full;
      fwd_get     = m_get & ~m_empty;
      a_get       = fwd_get & (state_reg == GNT_A);
      b_get       = fwd_get & (state_reg == GNT_B);
      m_dc        = (state_reg == GNT_B) ? b_dc   : a_dc;
      m_data      = (state_reg == GNT_B) ? b_data : a_data;
      grant       = state_reg;
   end

   // ------------------------------------------------------------------
   // Arbitration FSM: next state and burst bookkeeping
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      last_b_next = last_b_reg;
      burst_next  = burst_reg;

      // A burst ends on the get that fills it, or when the owner runs dry.
      // fwd_get already implies the owner is non-empty.
      rel = (state_reg != IDLE) &&
            ((fwd_get && (burst_reg == BURST_W'(MAX_BURST - 1))) || owner_empty);

      // While granted, the current owner is the one about to become
      // last-served, so round-robin is judged against it.
      prev_b = (state_reg == IDLE) ? last_b_reg : (state_reg == GNT_B);

      if (!prev_b) begin
         if (!b_empty)      pick = GNT_B;
         else if (!a_empty) pick = GNT_A;
         else               pick = IDLE;
      end else begin
         if (!a_empty)      pick = GNT_A;
         else if (!b_empty) pick = GNT_B;
         else               pick = IDLE;
      end

      if ((state_reg == IDLE) || rel) begin
         state_next = pick;
         burst_next = '0;
      end else if (fwd_get) begin
         burst_next = burst_reg + BURST_W'(1);
      end

      if (rel)
         last_b_next = (state_reg == GNT_B);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         last_b_reg <= 1'b1;       // B counts as last-served, so A wins first
         burst_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         last_b_reg <= last_b_next;
         burst_reg  <= burst_next;
      end
   end

   // ------------------------------------------------------------------
   // Return path: tag FIFO steering echoed bytes back to their owner
   // ------------------------------------------------------------------
   always_comb begin
      tag_nonempty = (tag_cnt_reg != '0);
      tag_head     = tag_mem[rd_ptr_reg];   // head must be visible in the put cycle
      tag_pop      = m_put & tag_nonempty;
      a_put        = tag_pop & ~tag_head;
      b_put        = tag_pop &  tag_head;
      a_out        = m_out;
      b_out        = m_out;
      m_full       = tag_nonempty & (tag_head ? b_full : a_full);
      orphan       = orphan_reg;
      orphan_next  = orphan_reg | (m_put & ~tag_nonempty);

      wr_ptr_next  = wr_ptr_reg;
      rd_ptr_next  = rd_ptr_reg;
      tag_cnt_next = tag_cnt_reg;

      if (fwd_get)
         wr_ptr_next = (wr_ptr_reg == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (tag_pop)
         rd_ptr_next = (rd_ptr_reg == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

      // Simultaneous push and pop leave the count unchanged.
      case ({fwd_get, tag_pop})
         2'b10:   tag_cnt_next = tag_cnt_reg + CNT_W'(1);
         2'b01:   tag_cnt_next = tag_cnt_reg - CNT_W'(1);
         default: tag_cnt_next = tag_cnt_reg;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         tag_cnt_reg <= '0;
         orphan_reg  <= 1'b0;
      end else begin
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         tag_cnt_reg <= tag_cnt_next;
         orphan_reg  <= orphan_next;
      end
   end

   // Tag storage needs no reset: entries are only read while the count says
   // they are valid.
   always_ff @(posedge clock) begin
      if (fwd_get)
         tag_mem[wr_ptr_reg] <= (state_reg == GNT_B);
   end

endmodule
